fifo_control: RTL and testbench

- Control and pointer engine that drives the FIFO storage RAM from the requester side.
- Converts push/pop requests into the RAM's write/read pointers and write/read enables.
- Tracks occupancy and produces full/empty, almost_full/almost_empty and error flags for the upstream flow-control logic in the transaction layer.
- Flags a valid data beat one cycle after each accepted read, to match the RAM's registered read port.

---
 rtl/fifo_control_if.sv | 41 ++++
 rtl/fifo_control.sv | 121 ++++++++++++
 tb/tb_fifo_control.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_control_if.sv
// Requester-side handshake bundle for the FIFO control engine.
// master: requester (drives push/pop, observes pointers, strobes and flags)
// slave : fifo_control (consumes push/pop, drives everything else)
//   push, pop            - per-cycle write/read requests
//   wr_ptr, rd_ptr       - RAM write/read addresses
//   write_enable         - RAM write strobe (push accepted)
//   read_enable          - RAM read strobe (pop accepted)
//   data_out_valid       - RAM read data valid (one cycle after read_enable)
//   count                - occupancy, 0..DEPTH
//   full, empty          - occupancy extremes
//   almost_full/_empty   - threshold flags
//   fifo_error           - sticky overflow/underflow flag
interface fifo_control_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  write_enable;
  logic                  read_enable;
  logic                  data_out_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;

  modport master (
    output push, pop,
    input  wr_ptr, rd_ptr, write_enable, read_enable, data_out_valid,
           count, full, empty, almost_full, almost_empty, fifo_error
  );

  modport slave (
    input  push, pop,
    output wr_ptr, rd_ptr, write_enable, read_enable, data_out_valid,
           count, full, empty, almost_full, almost_empty, fifo_error
  );
endinterface

// File: rtl/fifo_control.sv
// FIFO control and pointer engine driving a storage RAM with a registered
// read port. Turns push/pop requests into RAM addresses and strobes, tracks
// occupancy and raises flow-control flags.
// Ports:
//   clk   - single clock, all state on posedge
//   reset - synchronous, active-high
//   bus   - fifo_control_if.slave (push/pop in; pointers, strobes, flags out)
//
// state  | meaning
// VACIO  | count == 0, reads rejected
// ACTIVO | 0 < count < DEPTH, reads and writes accepted
// LLENO  | count == DEPTH, writes rejected
module fifo_control #(
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input logic           clk,
  input logic           reset,
  fifo_control_if.slave bus
);

  localparam int            CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] LAST_C  = CW'((2 ** ADDR_WIDTH) - 1);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_TH);

  typedef enum logic [1:0] {
    VACIO  = 2'd0,
    ACTIVO = 2'd1,
    LLENO  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  data_out_valid_q, data_out_valid_d;
  logic                  fifo_error_q, fifo_error_d;

  logic full, empty;
  logic wr_acc, rd_acc;

  // Flags come only from registered count, so push/pop reach nothing but
  // the two strobes combinationally.
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.push & ~full  & ~reset;
  assign rd_acc = bus.pop  & ~empty & ~reset;

  // State register (FSM plus pointer/occupancy datapath)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= VACIO;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      data_out_valid_q <= 1'b0;
      fifo_error_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      data_out_valid_q <= data_out_valid_d;
      fifo_error_q     <= fifo_error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      VACIO:  if (wr_acc) state_d = ACTIVO;
      ACTIVO: begin
        if (wr_acc && !rd_acc && count_q == LAST_C)
          state_d = LLENO;
        else if (rd_acc && !wr_acc && count_q == ONE_C)
          state_d = VACIO;
      end
      LLENO:  if (rd_acc) state_d = ACTIVO;
      default: state_d = VACIO;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap through natural ADDR_WIDTH overflow.
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // RAM read port is registered: data lands one cycle after the strobe.
    data_out_valid_d = rd_acc;
    // Any rejected request latches the error until reset.
    fifo_error_d     = fifo_error_q | (bus.push & full) | (bus.pop & empty);
  end

  // Output logic
  always_comb begin
    bus.write_enable   = wr_acc;
    bus.read_enable    = rd_acc;
    bus.wr_ptr         = wr_ptr_q;
    bus.rd_ptr         = rd_ptr_q;
    bus.count          = count_q;
    bus.full           = full;
    bus.empty          = empty;
    bus.almost_full    = (count_q >= AF_C);
    bus.almost_empty   = (count_q <= AE_C);
    bus.data_out_valid = data_out_valid_q;
    bus.fifo_error     = fifo_error_q;
  end

endmodule

// File: tb/tb_fifo_control.sv
// Bench for fifo_control: occupancy model compared every cycle, plus
// directed sequences with literal expectations.
module tb_fifo_control;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_control_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_control #(
    .ADDR_WIDTH     (AW),
    .ALMOST_FULL_TH (AF),
    .ALMOST_EMPTY_TH(AE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    else
      n_pass++;
  endtask

  // Behavioural model: occupancy counter and pointer positions.
  int m_cnt = 0, m_wr = 0, m_rd = 0;
  bit m_err = 0, m_dov = 0;
  bit chk_en = 0;
  bit exp_we, exp_re;

  always_comb begin
    exp_we = 1'b0;
    exp_re = 1'b0;
    exp_we = (bus.push === 1'b1) && (m_cnt < DEPTH) && !reset;
    exp_re = (bus.pop  === 1'b1) && (m_cnt > 0)     && !reset;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0; m_wr <= 0; m_rd <= 0; m_err <= 1'b0; m_dov <= 1'b0;
    end else begin
      m_cnt <= m_cnt + int'(exp_we) - int'(exp_re);
      m_wr  <= (m_wr + int'(exp_we)) % DEPTH;
      m_rd  <= (m_rd + int'(exp_re)) % DEPTH;
      m_err <= m_err || (bus.push && !exp_we) || (bus.pop && !exp_re);
      m_dov <= exp_re;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_we",    32'(bus.write_enable),   32'(exp_we));
      check("m_re",    32'(bus.read_enable),    32'(exp_re));
      check("m_wrptr", 32'(bus.wr_ptr),         m_wr);
      check("m_rdptr", 32'(bus.rd_ptr),         m_rd);
      check("m_count", 32'(bus.count),          m_cnt);
      check("m_full",  32'(bus.full),           32'(m_cnt == DEPTH));
      check("m_empty", 32'(bus.empty),          32'(m_cnt == 0));
      check("m_af",    32'(bus.almost_full),    32'(m_cnt >= AF));
      check("m_ae",    32'(bus.almost_empty),   32'(m_cnt <= AE));
      check("m_err",   32'(bus.fifo_error),     32'(m_err));
      check("m_dov",   32'(bus.data_out_valid), 32'(m_dov));
      n_checks++;
      assert ((bus.empty === (dut.state_q == 2'd0)) && (bus.full === (dut.state_q == 2'd2)))
        n_pass++;
      else
        $display("FAIL fsm_agree at %0t: full=%0b empty=%0b state=%0d",
                 $time, bus.full, bus.empty, dut.state_q);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input bit q);
    bus.push = p;
    bus.pop  = q;
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset then idle
    drive(0, 0);
    repeat (3) tick();
    check("rst_wrptr", 32'(bus.wr_ptr), 0);
    check("rst_rdptr", 32'(bus.rd_ptr), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_ae",    32'(bus.almost_empty), 1);
    check("rst_full",  32'(bus.full), 0);
    check("rst_err",   32'(bus.fifo_error), 0);
    check("rst_dov",   32'(bus.data_out_valid), 0);

    // Fill with 8 pushes
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0);
      check("fill_we", 32'(bus.write_enable), 1);
      check("fill_wrptr", 32'(bus.wr_ptr), 32'(k - 1));
      tick();
      check("fill_count", 32'(bus.count), 32'(k));
      check("fill_af", 32'(bus.almost_full), 32'(k >= 6));
      check("fill_ae", 32'(bus.almost_empty), 32'(k <= 2));
    end
    check("fill_wrap", 32'(bus.wr_ptr), 0);
    check("fill_full", 32'(bus.full), 1);

    // Overflow
    drive(1, 0);
    check("ovf_we", 32'(bus.write_enable), 0);
    tick();
    check("ovf_count", 32'(bus.count), 8);
    check("ovf_err", 32'(bus.fifo_error), 1);

    // Drain with 8 pops
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1);
      check("drain_re", 32'(bus.read_enable), 1);
      check("drain_rdptr", 32'(bus.rd_ptr), 32'(k - 1));
      tick();
      check("drain_dov", 32'(bus.data_out_valid), 1);
      check("drain_count", 32'(bus.count), 32'(8 - k));
    end
    check("drain_rdptr_end", 32'(bus.rd_ptr), 0);
    check("drain_empty", 32'(bus.empty), 1);

    // Underflow
    drive(0, 1);
    check("udf_re", 32'(bus.read_enable), 0);
    tick();
    check("udf_dov", 32'(bus.data_out_valid), 0);
    check("udf_err", 32'(bus.fifo_error), 1);

    // count=3 then 10 simultaneous push/pop
    for (int k = 0; k < 3; k++) begin
      drive(1, 0);
      tick();
    end
    check("pp_count0", 32'(bus.count), 3);
    for (int k = 0; k < 10; k++) begin
      drive(1, 1);
      check("pp_we", 32'(bus.write_enable), 1);
      check("pp_re", 32'(bus.read_enable), 1);
      tick();
      check("pp_count", 32'(bus.count), 3);
    end
    check("pp_wrptr", 32'(bus.wr_ptr), 5);
    check("pp_rdptr", 32'(bus.rd_ptr), 2);

    // Empty with push=pop=1
    do_reset();
    check("rst2_err", 32'(bus.fifo_error), 0);
    drive(1, 1);
    check("emp_pp_we", 32'(bus.write_enable), 1);
    check("emp_pp_re", 32'(bus.read_enable), 0);
    tick();
    check("emp_pp_count", 32'(bus.count), 1);
    check("emp_pp_err", 32'(bus.fifo_error), 1);
    check("emp_pp_wrptr", 32'(bus.wr_ptr), 1);
    check("emp_pp_rdptr", 32'(bus.rd_ptr), 0);

    // Full with push=pop=1
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1, 0);
      tick();
    end
    check("ful_pp_full0", 32'(bus.full), 1);
    check("ful_pp_err0", 32'(bus.fifo_error), 0);
    drive(1, 1);
    check("ful_pp_we", 32'(bus.write_enable), 0);
    check("ful_pp_re", 32'(bus.read_enable), 1);
    tick();
    check("ful_pp_count", 32'(bus.count), 7);
    check("ful_pp_err", 32'(bus.fifo_error), 1);
    check("ful_pp_rdptr", 32'(bus.rd_ptr), 1);
    check("ful_pp_wrptr", 32'(bus.wr_ptr), 0);

    // Reset mid-stream at count=5 while pushing
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0);
      tick();
    end
    check("mid_count", 32'(bus.count), 5);
    check("mid_wrptr", 32'(bus.wr_ptr), 5);
    reset = 1'b1;
    drive(1, 0);
    check("mid_rst_we", 32'(bus.write_enable), 0);
    tick();
    check("mid_rst_count", 32'(bus.count), 0);
    check("mid_rst_wrptr", 32'(bus.wr_ptr), 0);
    check("mid_rst_rdptr", 32'(bus.rd_ptr), 0);
    check("mid_rst_err", 32'(bus.fifo_error), 0);
    check("mid_rst_dov", 32'(bus.data_out_valid), 0);
    reset = 1'b0;
    drive(1, 0);
    check("post_rst_we", 32'(bus.write_enable), 1);
    check("post_rst_wrptr", 32'(bus.wr_ptr), 0);
    tick();
    check("post_rst_wrptr1", 32'(bus.wr_ptr), 1);
    check("post_rst_count", 32'(bus.count), 1);

    drive(0, 0);
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
